// File: rtl/mcpu_pkg.sv
//==============================================================================
// Module      : mcpu_pkg
// Description : Shared MCPU constants: ALU opcodes, core opcode field widths
//               and small decode helpers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mcpu_pkg;

    localparam int MCPU_INSTR_WIDTH = 8;
    localparam int MCPU_OP_WIDTH    = 3;
    localparam int ALU_OP_WIDTH     = 5;

    // Core-level instruction classes carried in instr[7:5]
    localparam logic [MCPU_OP_WIDTH-1:0] MCPU_OP_IMM  = 3'd0;
    localparam logic [MCPU_OP_WIDTH-1:0] MCPU_OP_MOV  = 3'd1;
    localparam logic [MCPU_OP_WIDTH-1:0] MCPU_OP_CMOV = 3'd2;
    localparam logic [MCPU_OP_WIDTH-1:0] MCPU_OP_LOAD = 3'd3;
    localparam logic [MCPU_OP_WIDTH-1:0] MCPU_OP_STOR = 3'd4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD   = 5'h00;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB   = 5'h01;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND   = 5'h02;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR    = 5'h03;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR   = 5'h04;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOT   = 5'h05;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SHL   = 5'h06;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SHR   = 5'h07;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SAR   = 5'h08;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_INC   = 5'h09;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DEC   = 5'h0A;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NEG   = 5'h0B;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_X     = 5'h0C;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_Y     = 5'h0D;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_A     = 5'h0E;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_B     = 5'h0F;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL   = 5'h10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_EQ    = 5'h11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NE    = 5'h12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LTU   = 5'h13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LT    = 5'h14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_GEU   = 5'h15;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_GE    = 5'h16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ZERO  = 5'h17;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SENSE = 5'h18;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_BIT   = 5'h19;

    // Compare ops report their condition as both flag and 0/1 result
    function automatic logic alu_op_is_compare(input logic [ALU_OP_WIDTH-1:0] op);
        return (op >= ALU_OP_EQ) && (op <= ALU_OP_BIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcpu_sync2.sv
//==============================================================================
// Module      : mcpu_sync2
// Description : Generic two-flop synchronizer, asynchronous active-high reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mcpu_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/mcpu_alu_unit.sv
//==============================================================================
// Module      : mcpu_alu_unit
// Description : Combinational MCPU ALU with a synchronized external sense line.
//               Optional multiplier for op 0x10 enabled by MCPU_ALU_MUL_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mcpu_alu_unit
    import mcpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] op,
    input  logic                  sense,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  f_out
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] C_WIDTH_VAL = DATA_WIDTH'(DATA_WIDTH);

    logic                    w_sense_s;
    logic [ALU_OP_WIDTH-1:0] w_op;
    logic                    w_unused_op;
    logic                    w_shift_oob;
    logic [SHW-1:0]          w_shamt;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_cond;
    logic                    w_use_cond;

    mcpu_sync2 u_sense_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (sense),
        .o_q   (w_sense_s)
    );

    assign w_op        = op[ALU_OP_WIDTH-1:0];
    assign w_unused_op = ^op[DATA_WIDTH-1:ALU_OP_WIDTH];

    // The whole of b is the shift amount; only in-range values reach the shifter
    assign w_shift_oob = (b >= C_WIDTH_VAL);
    assign w_shamt     = b[SHW-1:0];
    assign w_sum       = {1'b0, a} + {1'b0, b};

    always_comb begin
        w_res      = '0;
        w_cond     = 1'b0;
        w_use_cond = 1'b0;
        case (w_op)
            ALU_OP_ADD: begin
                w_res      = w_sum[DATA_WIDTH-1:0];
                w_cond     = w_sum[DATA_WIDTH];
                w_use_cond = 1'b1;
            end
            ALU_OP_SUB: begin
                w_res      = a - b;
                w_cond     = (a < b);
                w_use_cond = 1'b1;
            end
            ALU_OP_AND: w_res = a & b;
            ALU_OP_OR:  w_res = a | b;
            ALU_OP_XOR: w_res = a ^ b;
            ALU_OP_NOT: w_res = ~a;
            ALU_OP_SHL: w_res = w_shift_oob ? '0 : (a << w_shamt);
            ALU_OP_SHR: w_res = w_shift_oob ? '0 : (a >> w_shamt);
            ALU_OP_SAR: begin
                if (w_shift_oob) begin
                    w_res = {DATA_WIDTH{a[DATA_WIDTH-1]}};
                end else begin
                    w_res = $signed(a) >>> w_shamt;
                end
            end
            ALU_OP_INC: w_res = a + 1'b1;
            ALU_OP_DEC: w_res = a - 1'b1;
            ALU_OP_NEG: w_res = '0 - a;
            ALU_OP_X:   w_res = x;
            ALU_OP_Y:   w_res = y;
            ALU_OP_A:   w_res = a;
            ALU_OP_B:   w_res = b;
`ifdef MCPU_ALU_MUL_EN
            ALU_OP_MUL: w_res = a * b;
`endif
            ALU_OP_EQ:    begin w_cond = (a == b);                  w_use_cond = 1'b1; end
            ALU_OP_NE:    begin w_cond = (a != b);                  w_use_cond = 1'b1; end
            ALU_OP_LTU:   begin w_cond = (a < b);                   w_use_cond = 1'b1; end
            ALU_OP_LT:    begin w_cond = ($signed(a) < $signed(b)); w_use_cond = 1'b1; end
            ALU_OP_GEU:   begin w_cond = (a >= b);                  w_use_cond = 1'b1; end
            ALU_OP_GE:    begin w_cond = ($signed(a) >= $signed(b)); w_use_cond = 1'b1; end
            ALU_OP_ZERO:  begin w_cond = (a == '0);                 w_use_cond = 1'b1; end
            ALU_OP_SENSE: begin w_cond = w_sense_s;                 w_use_cond = 1'b1; end
            ALU_OP_BIT: begin
                w_cond     = w_shift_oob ? 1'b0 : a[w_shamt];
                w_use_cond = 1'b1;
            end
            // Undefined codes: result and flag both forced low
            default: begin
                w_res      = '0;
                w_cond     = 1'b0;
                w_use_cond = 1'b1;
            end
        endcase
    end

    assign d_out = alu_op_is_compare(w_op) ? DATA_WIDTH'(w_cond) : w_res;
    assign f_out = w_use_cond ? w_cond : (w_res != '0);

endmodule

`default_nettype wire

// File: tb/tb_mcpu_alu_unit.sv
//==============================================================================
// Module      : tb_mcpu_alu_unit
// Description : Self-checking bench for mcpu_alu_unit (DATA_WIDTH = 32).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mcpu_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a, b, x, y, op;
    logic        sense;
    logic [31:0] d_out;
    logic        f_out;

    int checks;
    int errors;

    mcpu_alu_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .x     (x),
        .y     (y),
        .op    (op),
        .sense (sense),
        .d_out (d_out),
        .f_out (f_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the op table evaluated with plain 64-bit arithmetic
    function automatic logic [32:0] model(input logic [31:0] opv, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic [31:0] mx,
                                          input logic [31:0] my, input logic ss);
        longint unsigned ua, ub, r;
        logic [31:0] d;
        logic        f;
        bit          cmp;
        int          code;
        ua   = {32'b0, ma};
        ub   = {32'b0, mb};
        code = int'(opv & 32'h1F);
        d    = 0;
        f    = 0;
        cmp  = 0;
        case (code)
            'h00: begin r = ua + ub; d = r[31:0]; f = r[32]; end
            'h01: begin d = 32'(ua - ub); f = (ua < ub); end
            'h02: d = ma & mb;
            'h03: d = ma | mb;
            'h04: d = ma ^ mb;
            'h05: d = ~ma;
            'h06: d = (ub >= 32) ? 32'h0 : 32'(ua << ub);
            'h07: d = (ub >= 32) ? 32'h0 : 32'(ua >> ub);
            'h08: begin
                if (ub >= 32) d = ma[31] ? 32'hFFFF_FFFF : 32'h0;
                else begin
                    r = ua;
                    for (int i = 0; i < int'(ub); i++) r = (r >> 1) | (ma[31] ? 64'h8000_0000 : 64'h0);
                    d = r[31:0];
                end
            end
            'h09: d = 32'(ua + 1);
            'h0A: d = 32'(ua + 64'hFFFF_FFFF);
            'h0B: d = 32'(64'h1_0000_0000 - ua);
            'h0C: d = mx;
            'h0D: d = my;
            'h0E: d = ma;
            'h0F: d = mb;
`ifdef MCPU_ALU_MUL_EN
            'h10: d = 32'(ua * ub);
`endif
            'h11: begin cmp = 1; f = (ua == ub); end
            'h12: begin cmp = 1; f = (ua != ub); end
            'h13: begin cmp = 1; f = (ua < ub); end
            'h14: begin cmp = 1; f = (longint'($signed(ma)) < longint'($signed(mb))); end
            'h15: begin cmp = 1; f = (ua >= ub); end
            'h16: begin cmp = 1; f = (longint'($signed(ma)) >= longint'($signed(mb))); end
            'h17: begin cmp = 1; f = (ua == 0); end
            'h18: begin cmp = 1; f = ss; end
            'h19: begin cmp = 1; f = (ub < 32) ? ((ua >> ub) & 64'h1) != 0 : 1'b0; end
            default: begin d = 0; f = 0; end
        endcase
        if (cmp) d = {31'b0, f};
        else if (code <= 'h10 && code != 'h00 && code != 'h01) f = (d != 0);
        return {f, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] exp_d, input logic exp_f);
        checks++;
        assert ({f_out, d_out} === {exp_f, exp_d})
        else begin
            errors++;
            $error("FAIL %s observed d=%h f=%b expected d=%h f=%b", tag, d_out, f_out, exp_d, exp_f);
        end
    endtask

    task automatic apply(input logic [31:0] vop, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vx, input logic [31:0] vy);
        @(negedge clk);
        op = vop; a = va; b = vb; x = vx; y = vy;
        #1;
    endtask

    task automatic rand_phase(input logic ss, input int n);
        logic [32:0] e;
        logic [31:0] rop, ra, rb;
        for (int i = 0; i < n; i++) begin
            rop = $urandom();
            ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            if ($urandom_range(0, 7) == 0) rb = ra;
            apply(rop, ra, rb, $urandom(), $urandom());
            e = model(rop, ra, rb, x, y, ss);
            check($sformatf("rand op=%0h a=%h b=%h", rop[4:0], ra, rb), e[31:0], e[32]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sense  = 1'b0;
        a = 0; b = 0; x = 0; y = 0; op = 32'h18;
        #1;
        check("reset_sense", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        apply(32'h00, 32'hFFFF_FFFF, 32'h1, 0, 0);          check("add_carry", 32'h0, 1'b1);
        apply(32'h01, 32'h3, 32'h5, 0, 0);                  check("sub_borrow", 32'hFFFF_FFFE, 1'b1);
        apply(32'h08, 32'h8000_0000, 32'h4, 0, 0);          check("sar_4", 32'hF800_0000, 1'b1);
        apply(32'h06, 32'h1234_5678, 32'd40, 0, 0);         check("shl_40", 32'h0, 1'b0);
        apply(32'h07, 32'h8000_0000, 32'd31, 0, 0);         check("shr_31", 32'h1, 1'b1);
        apply(32'h08, 32'h8000_0001, 32'd32, 0, 0);         check("sar_32", 32'hFFFF_FFFF, 1'b1);
        apply(32'h13, 32'hFFFF_FFFF, 32'h1, 0, 0);          check("ltu", 32'h0, 1'b0);
        apply(32'h14, 32'hFFFF_FFFF, 32'h1, 0, 0);          check("lt_signed", 32'h1, 1'b1);
        apply(32'h19, 32'h10, 32'h4, 0, 0);                 check("bit_4", 32'h1, 1'b1);
        apply(32'h19, 32'hFFFF_FFFF, 32'd32, 0, 0);         check("bit_oob", 32'h0, 1'b0);
        apply(32'h09, 32'hFFFF_FFFF, 32'h0, 0, 0);          check("inc_wrap", 32'h0, 1'b0);
        apply(32'h0C, 0, 0, 32'h1234_5678, 32'h0);          check("pass_x", 32'h1234_5678, 1'b1);
        apply(32'h0D, 0, 0, 32'h1234_5678, 32'h0);          check("pass_y", 32'h0, 1'b0);
        apply(32'h1F, 32'h5, 32'h7, 32'h9, 32'h9);          check("undef_1f", 32'h0, 1'b0);
        apply(32'hFFFF_FF00, 32'h2, 32'h3, 0, 0);           check("op_upper_ignored", 32'h5, 1'b0);
        apply(32'h10, 32'h7, 32'h6, 0, 0);
`ifdef MCPU_ALU_MUL_EN
        check("mul", 32'd42, 1'b1);
`else
        check("mul_disabled", 32'h0, 1'b0);
`endif

        // Sense synchronizer: rises on the second posedge after sense goes high
        apply(32'h18, 0, 0, 0, 0);
        sense = 1'b1;
        #1;                      check("sense_edge0", 32'h0, 1'b0);
        @(posedge clk); #1;      check("sense_edge1", 32'h0, 1'b0);
        @(posedge clk); #1;      check("sense_edge2", 32'h1, 1'b1);

        // Asynchronous reset mid-cycle clears the synchronized value at once
        #2 reset = 1'b1;
        #1;                      check("reset_async", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;                      check("rel_edge0", 32'h0, 1'b0);
        @(posedge clk); #1;      check("rel_edge1", 32'h0, 1'b0);
        @(posedge clk); #1;      check("rel_edge2", 32'h1, 1'b1);

        rand_phase(1'b1, 250);
        @(negedge clk);
        sense = 1'b0;
        repeat (3) @(posedge clk);
        rand_phase(1'b0, 250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
